// File: rtl/hilo_div_ctrl.sv
// HI/LO sequencer for the 32-cycle divider: 34 cycles per divide; issue_ready is low outside IDLE, so EX stalls.
// DIV_ZERO_BYPASS_EN: a zero divisor skips the divider and writes lo=all-ones, hi=dividend after one cycle.
module hilo_div_ctrl #(
  parameter int TIMEOUT = 48
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [1:0]  issue_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        issue_ready,
  input  logic        flush,
  input  logic        mf_req,
  input  logic        mf_sel,
  output logic [31:0] mf_data,
  output logic        stall,
  output logic        div_start,
  output logic        div_sign,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_busy,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_err
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_WB, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   dvd_q, dvd_d, dvs_q, dvs_d;
  logic          sign_q, sign_d, start_q, start_d, err_q, err_d, ready_q, ready_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;
`ifdef DIV_ZERO_BYPASS_EN
  logic          byp_q, byp_d;
`endif

  assign accept = issue_valid && ready_q && !flush;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    sign_d  = sign_q;
    start_d = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef DIV_ZERO_BYPASS_EN
    byp_d   = byp_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (issue_op[1]) begin
            if (issue_op[0]) lo_d = rs_val;
            else             hi_d = rs_val;
          end else begin
            dvd_d  = rs_val;
            dvs_d  = rt_val;
            sign_d = issue_op[0];
            cnt_d  = '0;
`ifdef DIV_ZERO_BYPASS_EN
            byp_d  = (rt_val == 32'd0);
            if (rt_val == 32'd0) begin
              state_d = S_WB;
            end else begin
              state_d = S_LAUNCH;
              start_d = 1'b1;
            end
`else
            state_d = S_LAUNCH;
            start_d = 1'b1;
`endif
          end
        end
      end
      S_LAUNCH: state_d = flush ? S_DRAIN : S_RUN;
      S_RUN, S_DRAIN: begin
        // Watchdog keeps counting in DRAIN so a stuck divider cannot wedge a flush.
        cnt_d = cnt_q + CW'(1);
        if (state_q == S_RUN && flush) begin
          state_d = S_DRAIN;
        end else if (!div_busy) begin
          state_d = (state_q == S_RUN) ? S_WB : S_IDLE;
        end else if (cnt_q >= CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WB: begin
`ifdef DIV_ZERO_BYPASS_EN
        if (byp_q) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = dvd_q;
        end else begin
          lo_d = div_q;
          hi_d = div_r;
        end
`else
        lo_d = div_q;
        hi_d = div_r;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      sign_q  <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      cnt_q   <= '0;
`ifdef DIV_ZERO_BYPASS_EN
      byp_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      sign_q  <= sign_d;
      start_q <= start_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
`ifdef DIV_ZERO_BYPASS_EN
      byp_q   <= byp_d;
`endif
    end
  end

  assign issue_ready  = ready_q;
  assign stall        = (issue_valid || mf_req) && !ready_q;
  assign mf_data      = mf_sel ? hi_q : lo_q;
  assign div_start    = start_q;
  assign div_sign     = sign_q;
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;
  assign hi           = hi_q;
  assign lo           = lo_q;
  assign div_err      = err_q;
endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl: vector table plus hand sequences, with a behavioural divider stub.
module tb_hilo_div_ctrl;
  localparam int TIMEOUT = 48;
  localparam logic [1:0] OP_DIVU = 2'b00, OP_DIV = 2'b01, OP_MTHI = 2'b10, OP_MTLO = 2'b11;

  logic        clock, reset, issue_valid, issue_ready, flush, mf_req, mf_sel, stall;
  logic [1:0]  issue_op;
  logic [31:0] rs_val, rt_val, mf_data, div_dividend, div_divisor, div_q, div_r, hi, lo;
  logic        div_start, div_sign, div_busy, div_err;

  hilo_div_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_op(issue_op),
    .rs_val(rs_val), .rt_val(rt_val), .issue_ready(issue_ready), .flush(flush),
    .mf_req(mf_req), .mf_sel(mf_sel), .mf_data(mf_data), .stall(stall),
    .div_start(div_start), .div_sign(div_sign), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_busy(div_busy), .div_q(div_q), .div_r(div_r),
    .hi(hi), .lo(lo), .div_err(div_err));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference arithmetic: quotient goes to LO, remainder to HI.
  function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Divider stub: samples start on the falling edge, 32 falling-edge iterations,
  // reads operands on the final one; hang keeps it busy forever.
  logic hang;
  int   it;
  always @(negedge clock or negedge reset) begin
    if (!reset) begin
      div_busy <= 1'b0;
      it       <= 0;
      div_q    <= '0;
      div_r    <= '0;
    end else if (div_start) begin
      div_busy <= 1'b1;
      it       <= 0;
    end else if (div_busy && !hang) begin
      if (it == 31) begin
        logic [31:0] q, r;
        ref_div(div_sign, div_dividend, div_divisor, q, r);
        div_q    <= q;
        div_r    <= r;
        div_busy <= 1'b0;
      end
      it <= it + 1;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Presents one op (assumes issue_ready), then counts not-ready cycles with mf_req held.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int nready, output int nstart, output int nstall, output logic sgn);
    issue_valid = 1'b1; issue_op = op; rs_val = a; rt_val = b;
    mf_req = 1'b1; mf_sel = 1'b0;
    step();
    issue_valid = 1'b0;
    sgn = div_sign;
    nready = 0; nstart = 0; nstall = 0;
    while (!issue_ready && nready < 200) begin
      if (div_start) nstart++;
      if (stall) nstall++;
      step();
      nready++;
    end
    mf_req = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, eh, el;
    int          cyc;
  } vec_t;

  vec_t tbl[$];

  function automatic int div_cycles(input logic [31:0] b);
`ifdef DIV_ZERO_BYPASS_EN
    return (b == 32'd0) ? 1 : 34;
`else
    return 34;
`endif
  endfunction

  initial begin
    logic [31:0] m_hi, m_lo, q, r, sv_hi, sv_lo;
    int nready, nstart, nstall;
    logic sgn;
    vec_t v;

    reset = 1'b0; issue_valid = 1'b0; issue_op = 2'b00; rs_val = '0; rt_val = '0;
    flush = 1'b0; mf_req = 1'b1; mf_sel = 1'b0; hang = 1'b0;
    repeat (3) step();
    chk("rst_ready", issue_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_start", div_start, 0);
    chk("rst_err", div_err, 0);
    chk("rst_dividend", div_dividend, 0);
    mf_req = 1'b0;
    reset = 1'b1;
    step();

    // Fixed vectors first, then random ones whose expectations come from the model.
    tbl.push_back('{OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34});
    tbl.push_back('{OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 34});
    tbl.push_back('{OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 34});
    m_hi = 32'd2; m_lo = 32'hFFFF_FFF2;
    for (int i = 0; i < 12; i++) begin
      v.op = 2'($urandom_range(0, 3));
      v.a  = $urandom;
      v.b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (v.b == 32'd0 || v.b == 32'hFFFF_FFFF) v.b = 32'd3;
      if (v.op == OP_MTHI) begin m_hi = v.a; v.cyc = 0; end
      else if (v.op == OP_MTLO) begin m_lo = v.a; v.cyc = 0; end
      else begin
        ref_div(v.op[0], v.a, v.b, q, r);
        m_lo = q; m_hi = r; v.cyc = div_cycles(v.b);
      end
      v.eh = m_hi; v.el = m_lo;
      tbl.push_back(v);
    end

    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, nready, nstart, nstall, sgn);
      chk($sformatf("v%0d_ready_cycles", i), nready, tbl[i].cyc);
      chk($sformatf("v%0d_start_pulses", i), nstart, tbl[i].op[1] ? 0 : 1);
      chk($sformatf("v%0d_stall_cycles", i), nstall, nready);
      if (!tbl[i].op[1]) chk($sformatf("v%0d_sign", i), sgn, tbl[i].op[0]);
      chk($sformatf("v%0d_hi", i), hi, tbl[i].eh);
      chk($sformatf("v%0d_lo", i), lo, tbl[i].el);
      mf_sel = 1'b1; #1;
      chk($sformatf("v%0d_mfhi", i), mf_data, tbl[i].eh);
      mf_sel = 1'b0;
    end

    // MTHI then immediate MFHI: no stall, value visible at once.
    do_op(OP_MTHI, 32'h1234, 32'd0, nready, nstart, nstall, sgn);
    mf_req = 1'b1; mf_sel = 1'b1; #1;
    chk("mthi_mfhi", mf_data, 32'h1234);
    chk("mthi_nostall", stall, 0);
    mf_req = 1'b0;
    step();

    // MTLO presented during a divide is held until IDLE.
    issue_valid = 1'b1; issue_op = OP_DIVU; rs_val = 32'd200; rt_val = 32'd9;
    step();
    issue_op = OP_MTLO; rs_val = 32'hBEEF;
    nready = 0; nstall = 0;
    while (!issue_ready && nready < 200) begin
      if (stall) nstall++;
      step();
      nready++;
    end
    chk("mtlo_held_cycles", nready, 34);
    chk("mtlo_stall_cycles", nstall, 34);
    chk("mtlo_div_lo", lo, 32'd22);
    step();
    issue_valid = 1'b0;
    chk("mtlo_lo", lo, 32'hBEEF);
    chk("mtlo_hi", hi, 32'd2);

    // Flush mid-divide: drain without touching HI/LO.
    sv_hi = hi; sv_lo = lo;
    issue_valid = 1'b1; issue_op = OP_DIVU; rs_val = 32'd50; rt_val = 32'd5;
    step();
    issue_valid = 1'b0;
    nready = 0;
    while (!issue_ready && nready < 200) begin
      flush = (nready == 9);
      step();
      nready++;
    end
    flush = 1'b0;
    chk("flush_ready_back", (nready >= 10 && nready <= 34), 1);
    chk("flush_busy_done", div_busy, 0);
    chk("flush_hi", hi, sv_hi);
    chk("flush_lo", lo, sv_lo);

    // Flush with an issue in IDLE: issue dropped.
    issue_valid = 1'b1; issue_op = OP_MTHI; rs_val = 32'h5555; flush = 1'b1;
    step();
    issue_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_hi", hi, sv_hi);
    chk("flush_idle_ready", issue_ready, 1);
    do_op(OP_DIVU, 32'd50, 32'd5, nready, nstart, nstall, sgn);
    chk("post_flush_cycles", nready, 34);
    chk("post_flush_lo", lo, 32'd10);
    chk("post_flush_hi", hi, 32'd0);

    // Zero divisor.
    do_op(OP_DIVU, 32'h77, 32'd0, nready, nstart, nstall, sgn);
`ifdef DIV_ZERO_BYPASS_EN
    chk("zero_cycles", nready, 1);
    chk("zero_starts", nstart, 0);
`else
    chk("zero_cycles", nready, 34);
    chk("zero_starts", nstart, 1);
`endif
    chk("zero_lo", lo, 32'hFFFF_FFFF);
    chk("zero_hi", hi, 32'h77);

    // Watchdog: divider stuck busy.
    sv_hi = hi; sv_lo = lo;
    hang = 1'b1;
    do_op(OP_DIVU, 32'd9, 32'd3, nready, nstart, nstall, sgn);
    chk("wdog_err", div_err, 1);
    chk("wdog_cycles", (nready >= TIMEOUT && nready <= TIMEOUT + 2), 1);
    chk("wdog_hi", hi, sv_hi);
    chk("wdog_lo", lo, sv_lo);
    hang = 1'b0;

    // Reset mid-RUN.
    issue_valid = 1'b1; issue_op = OP_DIVU; rs_val = 32'd1000; rt_val = 32'd3;
    step();
    issue_valid = 1'b0;
    repeat (10) step();
    chk("mid_run_busy", issue_ready, 0);
    reset = 1'b0; mf_req = 1'b1;
    #1;
    chk("mrst_ready", issue_ready, 1);
    chk("mrst_stall", stall, 0);
    chk("mrst_hi", hi, 0);
    chk("mrst_lo", lo, 0);
    chk("mrst_err", div_err, 0);
    chk("mrst_start", div_start, 0);
    chk("mrst_dividend", div_dividend, 0);
    mf_req = 1'b0;
    step();
    reset = 1'b1;
    step();
    do_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, nready, nstart, nstall, sgn);
    chk("restart_lo", lo, 32'hFFFF_FFF2);
    chk("restart_hi", hi, 32'hFFFF_FFFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
